fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch unit with a small in-order queue.
//
// Issues one instruction-memory request at a time from the current PC. Each
// accepted response is pushed into a DEPTH-entry circular queue as a
// {pc, instr} pair. The decode stage pops the head of the queue. A flush
// (redirect) empties the queue and discards any response that is still
// outstanding.
//
// Optional feature: define FETCH_QUEUE_PERF_EN to add the perf_fetched
// counter output.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-low
//   PC_Out       current fetch address from the PC register
//   PC_En        advance/load enable to the PC register
//   flush        redirect; the queue is cleared and the PC loads the target
//   imem_req     instruction-memory request (high while a request is outstanding)
//   imem_addr    request address, held stable until imem_ack
//   imem_ack     one-cycle response strobe
//   imem_rdata   instruction word, valid with imem_ack
//   if_valid     queue holds at least one entry
//   if_instr     head instruction (0 when empty)
//   if_pc        head PC (0 when empty)
//   id_ready     decode accepts the head entry
//   fq_count     current occupancy
//   perf_fetched (FETCH_QUEUE_PERF_EN only) count of non-discarded pushes
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            PC_Out,
  output logic                   PC_En,
  input  logic                   flush,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic [31:0]            if_pc,
  input  logic                   id_ready,
  output logic [$clog2(DEPTH):0] fq_count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]            perf_fetched
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   req_pc;
  logic          load_pc;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];

  // Next-state and push decode. Only one request is ever outstanding and a
  // new one is issued only when there is room, so a push cannot overflow.
  always_comb begin
    state_nxt = state;
    load_pc   = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && fq_count < FULL) begin
          state_nxt = REQ;
          load_pc   = 1'b1;
        end
      end
      REQ: begin
        if (flush) begin
          // A response in the flush cycle is simply dropped; otherwise the
          // request must still be drained before a new one can be issued.
          state_nxt = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PC advances after each accepted fetch and loads the redirect target on
  // flush. Gated by reset so the PC register sees no enable while in reset.
  assign PC_En     = reset & (flush | push);
  assign imem_req  = (state != IDLE);
  assign imem_addr = req_pc;
  assign if_valid  = (fq_count != '0);
  assign pop       = if_valid & id_ready;
  assign if_pc     = if_valid ? mem_pc[rd_ptr]    : 32'h0;
  assign if_instr  = if_valid ? mem_instr[rd_ptr] : 32'h0;

  // Control state. Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_pc   <= 32'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fq_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_pc) req_pc <= PC_Out;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fq_count <= '0;
      end else begin
        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      fq_count <= fq_count + 1'b1;
        else if (pop && !push) fq_count <= fq_count - 1'b1;
      end
    end
  end

  // Queue storage carries no reset; the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= req_pc;
      mem_instr[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    perf_fetched <= 32'h0;
    else if (push) perf_fetched <= perf_fetched + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed self-checking bench for fetch_queue (DEPTH=4).
// The bench models the PC register: when PC_En is seen at a clock edge the
// PC loads the redirect target (flush) or advances by 4.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [2:0] FULL = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_Out;
  logic        PC_En;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [2:0]  fq_count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched;
`endif

  logic [31:0] redirect;
  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .PC_Out     (PC_Out),
    .PC_En      (PC_En),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready),
    .fq_count   (fq_count)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_fetched (perf_fetched)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample the PC enable before the edge, flag any push into a
  // full queue, then update the modelled PC register after the edge.
  task automatic cyc();
    logic en, fl, ovf;
    @(negedge clk);
    en  = PC_En;
    fl  = flush;
    ovf = PC_En && !flush && (fq_count == FULL);
    total++;
    assert (!ovf) else begin
      bad++;
      $error("FAIL overflow_push observed=push@count%0d expected=no_push", fq_count);
    end
    @(posedge clk);
    #1;
    if (en) PC_Out = fl ? redirect : PC_Out + 32'd4;
  endtask

  // From IDLE with room: issue a request at pc and acknowledge it at once.
  task automatic fetch_one(input logic [31:0] pc);
    cyc();
    #1;
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, pc);
    imem_ack   = 1'b1;
    imem_rdata = instr_of(pc);
    #1;
    chk("fetch_pc_en", {31'b0, PC_En}, 32'd1);
    cyc();
    imem_ack = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    PC_Out     = 32'h3000;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    id_ready   = 1'b0;
    redirect   = 32'h0;
    #1;
    chk("rst_req",    {31'b0, imem_req}, 32'd0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_pc_en",  {31'b0, PC_En}, 32'd0);
    chk("rst_valid",  {31'b0, if_valid}, 32'd0);
    chk("rst_count",  {29'b0, fq_count}, 32'd0);
    chk("rst_if_pc",  if_pc, 32'h0);
    chk("rst_instr",  if_instr, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
    chk("rst_perf",   perf_fetched, 32'h0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;

    // First fetch, acknowledged two cycles after the request
    cyc();
    #1;
    chk("a_req",   {31'b0, imem_req}, 32'd1);
    chk("a_addr",  imem_addr, 32'h3000);
    chk("a_pc_en0", {31'b0, PC_En}, 32'd0);
    cyc();
    cyc();
    chk("a_addr_hold", imem_addr, 32'h3000);
    imem_ack   = 1'b1;
    imem_rdata = instr_of(32'h3000);
    #1;
    chk("a_pc_en1", {31'b0, PC_En}, 32'd1);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("a_pc_en2", {31'b0, PC_En}, 32'd0);
    chk("a_valid",  {31'b0, if_valid}, 32'd1);
    chk("a_if_pc",  if_pc, 32'h3000);
    chk("a_instr",  if_instr, instr_of(32'h3000));
    chk("a_count",  {29'b0, fq_count}, 32'd1);

    // Fill the queue with decode stalled
    fetch_one(32'h3004);
    fetch_one(32'h3008);
    fetch_one(32'h300C);
    #1;
    chk("b_count", {29'b0, fq_count}, 32'd4);
    chk("b_if_pc", if_pc, 32'h3000);
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      chk("b_no_req",   {31'b0, imem_req}, 32'd0);
      chk("b_no_pc_en", {31'b0, PC_En}, 32'd0);
      chk("b_count_hold", {29'b0, fq_count}, 32'd4);
    end

    // Single pop from a full queue, then the next request at 0x3010
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    #1;
    chk("c_if_pc", if_pc, 32'h3004);
    chk("c_count", {29'b0, fq_count}, 32'd3);
    chk("c_no_req", {31'b0, imem_req}, 32'd0);
    cyc();
    #1;
    chk("c_req",  {31'b0, imem_req}, 32'd1);
    chk("c_addr", imem_addr, 32'h3010);
    imem_ack   = 1'b1;
    imem_rdata = instr_of(32'h3010);
    #1;
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("c_count_full", {29'b0, fq_count}, 32'd4);

    // Drain all four entries; the last one sits in the wrapped slot
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("c_pop_pc",    if_pc, 32'h3004 + 32'(4 * i));
      chk("c_pop_instr", if_instr, instr_of(32'h3004 + 32'(4 * i)));
      cyc();
    end
    id_ready = 1'b0;
    #1;
    chk("c_empty_valid", {31'b0, if_valid}, 32'd0);
    chk("c_empty_pc",    if_pc, 32'h0);
    chk("c_empty_instr", if_instr, 32'h0);
    chk("c_empty_count", {29'b0, fq_count}, 32'd0);
    chk("c_req2",  {31'b0, imem_req}, 32'd1);
    chk("c_addr2", imem_addr, 32'h3014);

    // Flush while in REQ; ack arrives three cycles later and is dropped
    redirect = 32'h5000;
    flush    = 1'b1;
    #1;
    chk("d_pc_en_flush", {31'b0, PC_En}, 32'd1);
    cyc();
    flush = 1'b0;
    #1;
    chk("d_count",   {29'b0, fq_count}, 32'd0);
    chk("d_pc_en0",  {31'b0, PC_En}, 32'd0);
    chk("d_drain_req", {31'b0, imem_req}, 32'd1);
    cyc();
    cyc();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("d_pc_en_late", {31'b0, PC_En}, 32'd0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("d_no_push", {29'b0, fq_count}, 32'd0);
    chk("d_valid",   {31'b0, if_valid}, 32'd0);
    chk("d_idle",    {31'b0, imem_req}, 32'd0);
    cyc();
    #1;
    chk("d_redirect_addr", imem_addr, 32'h5000);

    // Flush, ack and pop in the same cycle
    imem_ack   = 1'b1;
    imem_rdata = instr_of(32'h5000);
    #1;
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("e_count1", {29'b0, fq_count}, 32'd1);
    chk("e_if_pc",  if_pc, 32'h5000);
    cyc();
    #1;
    chk("e_addr", imem_addr, 32'h5004);
    redirect   = 32'h6000;
    flush      = 1'b1;
    imem_ack   = 1'b1;
    id_ready   = 1'b1;
    imem_rdata = instr_of(32'h5004);
    #1;
    chk("e_pc_en", {31'b0, PC_En}, 32'd1);
    cyc();
    flush    = 1'b0;
    imem_ack = 1'b0;
    id_ready = 1'b0;
    #1;
    chk("e_count0", {29'b0, fq_count}, 32'd0);
    chk("e_valid",  {31'b0, if_valid}, 32'd0);
    chk("e_idle",   {31'b0, imem_req}, 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
    chk("e_perf",   perf_fetched, 32'd6);
`endif

    // Reset in the middle of a request, then a stale ack after release
    cyc();
    #1;
    chk("f_req",  {31'b0, imem_req}, 32'd1);
    chk("f_addr", imem_addr, 32'h6000);
    reset = 1'b0;
    #1;
    chk("f_rst_req",   {31'b0, imem_req}, 32'd0);
    chk("f_rst_addr",  imem_addr, 32'h0);
    chk("f_rst_pc_en", {31'b0, PC_En}, 32'd0);
    chk("f_rst_valid", {31'b0, if_valid}, 32'd0);
    chk("f_rst_count", {29'b0, fq_count}, 32'd0);
    chk("f_rst_if_pc", if_pc, 32'h0);
    chk("f_rst_instr", if_instr, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
    chk("f_rst_perf",  perf_fetched, 32'h0);
`endif
    cyc();
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    #1;
    chk("f_stale_pc_en", {31'b0, PC_En}, 32'd0);
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("f_stale_count", {29'b0, fq_count}, 32'd0);
    chk("f_stale_valid", {31'b0, if_valid}, 32'd0);
    chk("f_new_req",     {31'b0, imem_req}, 32'd1);
    chk("f_new_addr",    imem_addr, 32'h6000);
`ifdef FETCH_QUEUE_PERF_EN
    chk("f_perf",        perf_fetched, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
